// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
// regfile_mp: multi-port register file with post-reset clear sequencer, write bypass
// and an optional pending-write scoreboard (define REGFILE_SCOREBOARD_EN to enable).
module regfile_mp #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_READ = 2,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_READ*ADDR_W-1:0]   ra,
  output logic [NUM_READ*WIDTH-1:0]    rdata,
  input  logic                         we0,
  input  logic [ADDR_W-1:0]            waddr0,
  input  logic [WIDTH-1:0]             wdata0,
  input  logic                         we1,
  input  logic [ADDR_W-1:0]            waddr1,
  input  logic [WIDTH-1:0]             wdata1,
  input  logic                         rsv_en,
  input  logic [ADDR_W-1:0]            rsv_addr,
  output logic [NUM_READ-1:0]          rbusy,
  output logic                         ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic              clr_we;
  logic              run;
  logic [WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= ADDR_W'(1);
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_we     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we   = 1'b1;
        cnt_next = cnt + ADDR_W'(1);
        if (cnt == ADDR_W'(DEPTH - 1))
          state_next = RUN;
      end
      RUN: ;
      default: state_next = CLEAR;
    endcase
  end

  assign run   = (state == RUN);
  assign ready = run;

  // No reset on the array so it can map to RAM; port 1 is written last so it wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (run) begin
      if (we0 && waddr0 != '0) mem[waddr0] <= wdata0;
      if (we1 && waddr1 != '0) mem[waddr1] <= wdata1;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pending;

  // Reserve is applied after the write clears so a newer producer keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (!run) begin
      pending <= '0;
    end else begin
      if (we0 && waddr0 != '0)     pending[waddr0]   <= 1'b0;
      if (we1 && waddr1 != '0)     pending[waddr1]   <= 1'b0;
      if (rsv_en && rsv_addr != '0) pending[rsv_addr] <= 1'b1;
    end
  end
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_en, rsv_addr};
`endif

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDR_W-1:0] a;
    logic              hit0, hit1;
    logic [WIDTH-1:0]  d;

    assign a    = ra[i*ADDR_W +: ADDR_W];
    assign hit1 = (BYPASS != 0) && we1 && (waddr1 == a);
    assign hit0 = (BYPASS != 0) && we0 && (waddr0 == a);

    always_comb begin
      d = '0;
      if (run && a != '0) begin
        if (hit1)      d = wdata1;
        else if (hit0) d = wdata0;
        else           d = mem[a];
      end
    end

    assign rdata[i*WIDTH +: WIDTH] = d;

`ifdef REGFILE_SCOREBOARD_EN
    assign rbusy[i] = run && (a != '0) && pending[a] && !(hit0 || hit1);
`else
    assign rbusy[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
// tb_regfile_mp: scoreboard bench for regfile_mp; a bypassing and a non-bypassing
// instance share all inputs and a negedge monitor checks queued expectations.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int AW = 5;

`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  typedef enum int {K_READY, K_READY_NB, K_RD, K_RD_NB, K_BUSY, K_BUSY_NB} kind_t;

  typedef struct {
    kind_t      kind;
    int         port;
    logic [W-1:0] exp;
    string      name;
  } item_t;

  logic          clk, rst_n;
  logic [AW-1:0] ra0, ra1;
  logic [2*AW-1:0] ra;
  logic          we0, we1, rsv_en;
  logic [AW-1:0] waddr0, waddr1, rsv_addr;
  logic [W-1:0]  wdata0, wdata1;
  logic [2*W-1:0] rdata, rdata_nb;
  logic [1:0]    rbusy, rbusy_nb;
  logic          ready, ready_nb;

  item_t sb[$];
  int    errors = 0;
  int    checks = 0;

  assign ra = {ra1, ra0};

  regfile_mp #(.WIDTH(W), .DEPTH(32), .NUM_READ(2), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rdata(rdata),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rbusy(rbusy), .ready(ready)
  );

  regfile_mp #(.WIDTH(W), .DEPTH(32), .NUM_READ(2), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rdata(rdata_nb),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rbusy(rbusy_nb), .ready(ready_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void expect_out(kind_t kind, int port, logic [W-1:0] exp, string name);
    item_t it;
    it.kind = kind;
    it.port = port;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endfunction

  function automatic void check_output(item_t it);
    logic [W-1:0] act;
    act = '0;
    case (it.kind)
      K_READY:    act = W'(ready);
      K_READY_NB: act = W'(ready_nb);
      K_RD:       act = rdata[it.port*W +: W];
      K_RD_NB:    act = rdata_nb[it.port*W +: W];
      K_BUSY:     act = W'(rbusy);
      K_BUSY_NB:  act = W'(rbusy_nb);
      default:    act = 'x;
    endcase
    checks++;
    if (act !== it.exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", it.name, act, it.exp, $time);
    end
  endfunction

  // Monitor: every queued expectation is compared mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    while (sb.size() > 0) check_output(sb.pop_front());
  end

  task automatic apply_stimulus(input logic e0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                                input logic e1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                                input logic rv, input logic [AW-1:0] rva,
                                input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(posedge clk);
    #1;
    we0 = e0; waddr0 = a0; wdata0 = d0;
    we1 = e1; waddr1 = a1; wdata1 = d1;
    rsv_en = rv; rsv_addr = rva;
    ra0 = r0; ra1 = r1;
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  task automatic expect_ready(input logic r, input string name);
    expect_out(K_READY, 0, W'(r), name);
    expect_out(K_READY_NB, 0, W'(r), name);
  endtask

  task automatic expect_busy(input logic [1:0] b, input logic [1:0] bnb, input string name);
    expect_out(K_BUSY, 0, W'(b), name);
    expect_out(K_BUSY_NB, 0, W'(bnb), name);
  endtask

  initial begin
    rst_n = 1'b0;
    we0 = 0; waddr0 = 0; wdata0 = 0;
    we1 = 0; waddr1 = 0; wdata1 = 0;
    rsv_en = 0; rsv_addr = 0; ra0 = 0; ra1 = 0;

    idle(5, 7);
    expect_ready(1'b0, "reset_ready");
    expect_out(K_RD, 0, 32'h0, "reset_rdata0");
    expect_out(K_RD_NB, 1, 32'h0, "reset_rdata1_nb");
    expect_busy(2'b00, 2'b00, "reset_rbusy");
    @(negedge clk); #1 rst_n = 1'b1;

    // Partial clear interrupted by reset after 10 edges.
    for (int k = 1; k <= 10; k++) begin
      idle(0, 0);
      expect_ready(1'b0, "partial_clear_ready");
    end
    @(negedge clk); #1 rst_n = 1'b0;
    idle(0, 0);
    expect_ready(1'b0, "reclear_reset_ready");
    @(negedge clk); #1 rst_n = 1'b1;

    // Full clear: writes and reserves must be ignored; ready after exactly 31 edges.
    for (int k = 1; k <= 31; k++) begin
      if (k == 3) begin
        apply_stimulus(1, 20, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 20, 0);
        expect_out(K_RD, 0, 32'h0, "clear_rdata_forced");
      end else if (k == 5) begin
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 7);
      end else if (k == 25) begin
        apply_stimulus(0, 0, 0, 1, 20, 32'h5A5A5A5A, 0, 0, 0, 0);
      end else begin
        idle(0, 0);
      end
      expect_ready(k == 31, "clear_ready_timing");
    end

    for (int a = 0; a < 16; a++) begin
      idle(AW'(2*a), AW'(2*a + 1));
      expect_out(K_RD, 0, 32'h0, "sweep_rd0");
      expect_out(K_RD, 1, 32'h0, "sweep_rd1");
      expect_out(K_RD_NB, 0, 32'h0, "sweep_rd0_nb");
      expect_out(K_RD_NB, 1, 32'h0, "sweep_rd1_nb");
      expect_busy(2'b00, 2'b00, "sweep_rbusy");
    end

    // Bypass, write priority and register 0.
    apply_stimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 9);
    expect_out(K_RD, 0, 32'hDEADBEEF, "bypass_w0");
    expect_out(K_RD_NB, 0, 32'h0, "nobypass_old");
    expect_out(K_RD, 1, 32'h0, "bypass_other_port");
    idle(5, 9);
    expect_out(K_RD, 0, 32'hDEADBEEF, "stored_w0");
    expect_out(K_RD_NB, 0, 32'hDEADBEEF, "nobypass_next");
    apply_stimulus(1, 9, 32'h11111111, 1, 9, 32'h22222222, 0, 0, 9, 5);
    expect_out(K_RD, 0, 32'h22222222, "bypass_port1_wins");
    expect_out(K_RD_NB, 0, 32'h0, "nobypass_dual_old");
    expect_out(K_RD, 1, 32'hDEADBEEF, "read_other_reg");
    idle(9, 5);
    expect_out(K_RD, 0, 32'h22222222, "stored_port1_wins");
    expect_out(K_RD_NB, 0, 32'h22222222, "stored_port1_wins_nb");
    apply_stimulus(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    expect_out(K_RD, 0, 32'h0, "r0_bypass_blocked");
    expect_out(K_RD, 1, 32'h0, "r0_bypass_blocked_p1");
    apply_stimulus(1, 13, 32'h0BADF00D, 1, 12, 32'h12345678, 0, 0, 13, 12);
    expect_out(K_RD, 0, 32'h0BADF00D, "bypass_p0_r13");
    expect_out(K_RD, 1, 32'h12345678, "bypass_p1_r12");
    idle(0, 12);
    expect_out(K_RD, 0, 32'h0, "r0_after_write");
    expect_out(K_RD_NB, 0, 32'h0, "r0_after_write_nb");
    expect_out(K_RD_NB, 1, 32'h12345678, "stored_r12_nb");

    // Scoreboard behaviour (all-zero busy when the feature is compiled out).
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 7, 3, 7);
    expect_busy(2'b00, 2'b00, "rsv_same_cycle");
    idle(7, 7);
    expect_busy(SB ? 2'b11 : 2'b00, SB ? 2'b11 : 2'b00, "rsv_pending");
    apply_stimulus(1, 7, 32'h77, 0, 0, 0, 0, 0, 3, 7);
    expect_busy(2'b00, SB ? 2'b10 : 2'b00, "write_masks_busy");
    expect_out(K_RD, 1, 32'h77, "write_r7_bypass");
    idle(3, 7);
    expect_busy(2'b00, 2'b00, "write_clears_pending");
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 7, 3, 7);
    expect_busy(2'b00, 2'b00, "rsv_again");
    apply_stimulus(1, 7, 32'h88, 0, 0, 0, 1, 7, 3, 7);
    expect_busy(2'b00, SB ? 2'b10 : 2'b00, "rsv_and_write");
    idle(3, 7);
    expect_busy(SB ? 2'b10 : 2'b00, SB ? 2'b10 : 2'b00, "rsv_wins");
    apply_stimulus(0, 0, 0, 1, 7, 32'h99, 0, 0, 3, 7);
    expect_busy(2'b00, SB ? 2'b10 : 2'b00, "write1_masks_busy");
    idle(3, 7);
    expect_busy(2'b00, 2'b00, "write1_clears");
    expect_out(K_RD_NB, 1, 32'h99, "stored_r7_nb");

    // Reset while running: outputs drop at once and the file is re-cleared.
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 7, 5, 7);
    idle(5, 7);
    expect_busy(SB ? 2'b10 : 2'b00, SB ? 2'b10 : 2'b00, "pending_before_reset");
    @(negedge clk); #1 rst_n = 1'b0;
    idle(5, 7);
    expect_ready(1'b0, "run_reset_ready");
    expect_out(K_RD, 0, 32'h0, "run_reset_rdata");
    expect_busy(2'b00, 2'b00, "run_reset_rbusy");
    @(negedge clk); #1 rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      idle(5, 7);
      expect_ready(k == 31, "reclear_ready_timing");
    end
    idle(5, 7);
    expect_out(K_RD, 0, 32'h0, "reclear_r5");
    expect_out(K_RD_NB, 1, 32'h0, "reclear_r7_nb");
    expect_busy(2'b00, 2'b00, "reclear_pending");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, two-read pipeline register file.
- Sits in ID/WB of the pipelined MIPS core: N combinational read ports, two synchronous write ports (WB and a secondary load/link port).
- Adds optional write-through bypass, a post-reset clear sequencer with a ready flag, and an optional pending-write scoreboard.
- Storage has no per-entry reset, so it can map to RAM/LUTRAM.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 32, number of registers; power of two, >=4. ADDR_W = $clog2(DEPTH) is a localparam.
- NUM_READ, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return the stored value.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ra  in  NUM_READ*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_READ*WIDTH  read data, port i at [i*WIDTH +: WIDTH].
- we0  in  1  write enable, port 0 (WB).
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  WIDTH  write data, port 0.
- we1  in  1  write enable, port 1 (secondary).
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  WIDTH  write data, port 1.
- rsv_en  in  1  reserve destination (scoreboard).
- rsv_addr  in  ADDR_W  register to reserve.
- rbusy  out  NUM_READ  per read port: source has a pending write.
- ready  out  1  clear sequence done; file usable.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - ready=0; clear counter loads 1; scoreboard pending bits cleared.
  - All rdata=0 and rbusy=0.
- FSM has two states, CLEAR and RUN.
- CLEAR:
  - Each rising edge writes 0 to entry cnt, then increments cnt.
  - After the edge that clears entry DEPTH-1, go to RUN and set ready=1. ready rises exactly DEPTH-1 edges after rst_n deasserts (31 for the default).
  - we0, we1 and rsv_en are ignored. rdata and rbusy are forced to 0.
- Reset reasserted mid-CLEAR or in RUN: immediately return to CLEAR with cnt=1. Stored contents are don't-care until re-cleared.
- RUN writes:
  - On the rising edge, mem[waddrN] <= wdataN when weN=1 and waddrN!=0.
  - Both ports writing the same address: port 1 wins.
  - Writes to address 0 are dropped.
- Reads are combinational:
  - ra_i==0 -> rdata_i=0 always.
  - BYPASS=1: if we1 && waddr1==ra_i && ra_i!=0, return wdata1. Else if we0 && waddr0==ra_i && ra_i!=0, return wdata0. Else return mem[ra_i].
  - BYPASS=0: always return mem[ra_i]; the new value is visible the cycle after the write edge.
- Entry 0 is never written, including by CLEAR; it reads 0 by construction.
- Read-port count and widths come purely from parameters. No functional limit on all ports reading the same address.

Optional Feature:
- Macro REGFILE_SCOREBOARD_EN.
- Defined: a DEPTH-bit pending vector.
  - Rising edge in RUN: pending[rsv_addr] <= 1 if rsv_en and rsv_addr!=0.
  - pending[waddrN] <= 0 for each active write.
  - Reserve and write to the same address in the same cycle: reserve wins (newer producer), bit stays 1.
  - rbusy_i = ra_i!=0 && pending[ra_i] && !(BYPASS && a same-cycle write to ra_i).
  - Pending bits are cleared asynchronously by reset and are held at 0 during CLEAR.
- Not defined: no pending storage; rbusy tied to 0; rsv_en and rsv_addr ignored. Port list is unchanged.

Test Plan:
- Release reset, no stimulus -> ready=0 for exactly 31 edges, ready=1 after the 31st; every ra in 0..31 then reads 0x00000000.
- In RUN, we0=1, waddr0=5, wdata0=0xDEADBEEF, ra[0]=5 in the same cycle -> BYPASS=1: rdata0=0xDEADBEEF that cycle. BYPASS=0: old value that cycle, 0xDEADBEEF the next.
- Same cycle we0/we1 both to reg 9 with 0x11111111/0x22222222 -> reg 9 reads 0x22222222. Write 0xFFFFFFFF to reg 0 -> ra=0 still reads 0.
- Write during CLEAR at cycle 3 to reg 20 with 0xA5A5A5A5 -> after ready, reg 20 reads 0. Assert rst_n=0 at CLEAR cycle 10 -> ready stays 0, and the sequence restarts with a full 31 edges after release.
- REGFILE_SCOREBOARD_EN: rsv_en reg 7 -> next cycle ra[1]=7 gives rbusy[1]=1. Write reg 7 with BYPASS=1 -> rbusy[1]=0 in the write cycle, and the bit is cleared after the edge. Reserve and write reg 7 in the same cycle -> rbusy stays 1.
- Without macro: rsv_en reg 7 pulse -> rbusy remains 0 on all ports for all cycles.
